// File: rtl/sipo_burst_sched.sv
// Round-robin burst scheduler: steers BURST_LEN bytes from the SIPO valid/ready port to one granted consumer at a time.
// Optional stall-abort logic is compiled in with `define SCHED_TIMEOUT_EN.
module sipo_burst_sched #(
  parameter int NUM_CH      = 4,
  parameter int BURST_LEN   = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              pclk_i,
  input  logic              rst_i,
  input  logic [7:0]        s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [NUM_CH-1:0] req_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [7:0]        m_data_o,
  output logic [NUM_CH-1:0] m_valid_o,
  input  logic [NUM_CH-1:0] m_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic              state_dbg_o
);

  localparam int PTR_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [NUM_CH-1:0] r_gnt, w_gnt_nxt;
  logic [PTR_W-1:0]  r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0]  r_win, w_win_nxt;
  logic [PTR_W-1:0]  w_arb_idx;
  logic              w_arb_found;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_done, w_done_nxt;
  logic              r_timeout, w_timeout_nxt;
  logic              w_s_ready;
  logic              w_beat;
  logic              w_last;
  logic              w_abort;

  // Handshake: a byte moves only when s_valid_i and s_ready_o are both high in the same cycle;
  // s_ready_o reflects only the granted consumer's m_ready_i, so the SIPO holds its byte otherwise.
  assign w_s_ready = (r_state == S_XFER) && |(r_gnt & m_ready_i);
  assign w_beat    = s_valid_i & w_s_ready;
  assign w_last    = w_beat && (r_cnt == CNT_W'(BURST_LEN - 1));

  // Winner is the first requester after the last-served channel, so that channel ranks lowest.
  always_comb begin
    int w_idx;
    w_idx       = 0;
    w_arb_idx   = r_ptr;
    w_arb_found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_idx = (int'(r_ptr) + i) % NUM_CH;
      if (!w_arb_found && req_i[PTR_W'(w_idx)]) begin
        w_arb_idx   = PTR_W'(w_idx);
        w_arb_found = 1'b1;
      end
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int ST_W = $clog2(TIMEOUT_CYC + 1);
  logic [ST_W-1:0] r_stall;

  assign w_abort = (r_state == S_XFER) && !w_beat && (r_stall == ST_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall <= '0;
    end else if (r_state != S_XFER || w_beat) begin
      r_stall <= '0;
    end else begin
      r_stall <= r_stall + ST_W'(1);
    end
  end
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT_CYC);
  assign w_abort          = 1'b0;
`endif

  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_ptr     <= PTR_W'(NUM_CH - 1);
      r_win     <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_win     <= w_win_nxt;
      r_cnt     <= w_cnt_nxt;
      r_done    <= w_done_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_ptr_nxt     = r_ptr;
    w_win_nxt     = r_win;
    w_cnt_nxt     = r_cnt;
    w_done_nxt    = 1'b0;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arb_found) begin
          w_state_nxt = S_XFER;
          w_gnt_nxt   = NUM_CH'(1) << w_arb_idx;
          w_win_nxt   = w_arb_idx;
          w_cnt_nxt   = '0;
        end
      end
      S_XFER: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = r_win;
          w_done_nxt  = 1'b1;
        end else if (w_abort) begin
          w_state_nxt   = S_IDLE;
          w_gnt_nxt     = '0;
          w_ptr_nxt     = r_win;
          w_timeout_nxt = 1'b1;
        end else if (w_beat) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (r_state == S_XFER);
    state_dbg_o = r_state;
    gnt_o       = r_gnt;
    done_o      = r_done;
    timeout_o   = r_timeout;
    s_ready_o   = w_s_ready;
    m_data_o    = s_data_i;
    m_valid_o   = (r_state == S_XFER) ? (r_gnt & {NUM_CH{s_valid_i}}) : '0;
  end

endmodule

// File: tb/tb_sipo_burst_sched.sv
// Bench for sipo_burst_sched: directed scenarios plus random traffic against a burst-level reference model.
// Define SCHED_TIMEOUT_EN for both bench and RTL to cover the stall-abort path.
module tb_sipo_burst_sched;
  localparam int NCH    = 4;
  localparam int BL     = 8;
  localparam int TO_CYC = 16;

  logic           pclk = 1'b0;
  logic           rst  = 1'b0;
  logic [7:0]     s_data_i  = '0;
  logic           s_valid_i = 1'b0;
  logic           s_ready_o;
  logic [NCH-1:0] req_i     = '0;
  logic [NCH-1:0] gnt_o;
  logic [7:0]     m_data_o;
  logic [NCH-1:0] m_valid_o;
  logic [NCH-1:0] m_ready_i = '0;
  logic           busy_o, done_o, timeout_o, state_dbg;

  sipo_burst_sched #(.NUM_CH(NCH), .BURST_LEN(BL), .TIMEOUT_CYC(TO_CYC)) dut (
    .pclk_i(pclk), .rst_i(rst),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .req_i(req_i), .gnt_o(gnt_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .state_dbg_o(state_dbg)
  );

  always #5 pclk = ~pclk;

  int          checks = 0;
  int          errors = 0;
  logic [10:0] exp_q[$];

  // Reference model: which channel owns the bus, how many bytes it has had, who was served last.
  bit m_busy = 0, m_done = 0, m_to = 0;
  int m_win = 0, m_cnt = 0, m_ptr = NCH - 1, m_stall = 0;

  logic [NCH-1:0] obs_gnt = '0;
  logic           obs_busy = 1'b0, obs_to = 1'b0, last_beat = 1'b0;
  logic [7:0]     nb = 8'h11;
  int             mon_beats = 0;
  logic [2:0]     mon_ch;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_to = 0; m_win = 0; m_cnt = 0; m_ptr = NCH - 1; m_stall = 0;
  endtask

  task automatic model_step(input logic [NCH-1:0] req, input logic beat);
    m_done = 0;
    m_to   = 0;
    if (!m_busy) begin
      for (int i = 1; i <= NCH; i++) begin
        int idx = (m_ptr + i) % NCH;
        if (req[idx]) begin
          m_win = idx; m_busy = 1; m_cnt = 0; m_stall = 0;
          break;
        end
      end
    end else if (beat) begin
      m_stall = 0;
      m_cnt++;
      if (m_cnt == BL) begin
        m_done = 1; m_ptr = m_win; m_busy = 0;
      end
    end
`ifdef SCHED_TIMEOUT_EN
    else begin
      m_stall++;
      if (m_stall == TO_CYC) begin
        m_to = 1; m_ptr = m_win; m_busy = 0;
      end
    end
`endif
  endtask

  // One clock: drive at negedge, check against the model, push the expected beat, advance the model.
  task automatic cycle(input logic [NCH-1:0] req, input logic sv, input logic [7:0] sd,
                       input logic [NCH-1:0] mr);
    logic [NCH-1:0] e_gnt;
    @(negedge pclk);
    req_i = req; s_valid_i = sv; s_data_i = sd; m_ready_i = mr;
    #1;
    e_gnt = m_busy ? (NCH'(1) << m_win) : '0;
    chk("gnt",       32'(gnt_o),     32'(e_gnt));
    chk("busy",      32'(busy_o),    32'(m_busy));
    chk("state_dbg", 32'(state_dbg), 32'(m_busy));
    chk("done",      32'(done_o),    32'(m_done));
    chk("timeout",   32'(timeout_o), 32'(m_to));
    chk("s_ready",   32'(s_ready_o), 32'(m_busy && mr[m_win]));
    chk("m_valid",   32'(m_valid_o), 32'(sv ? e_gnt : '0));
    chk("m_data",    32'(m_data_o),  32'(sd));
    obs_gnt  = gnt_o;
    obs_busy = busy_o;
    obs_to   = timeout_o;
    last_beat = m_busy && sv && mr[m_win];
    if (last_beat) begin
      exp_q.push_back({3'(m_win), sd});
      nb++;
    end
    @(posedge pclk);
    model_step(req, last_beat);
  endtask

  // Called just after a rising edge, so reset lands in the middle of the clock-high phase.
  task automatic do_reset();
    #2;
    rst = 1'b1; req_i = '0; s_valid_i = 1'b0; m_ready_i = '0;
    #1;
    chk("rst_gnt",     32'(gnt_o),     0);
    chk("rst_busy",    32'(busy_o),    0);
    chk("rst_s_ready", 32'(s_ready_o), 0);
    chk("rst_done",    32'(done_o),    0);
    chk("rst_timeout", 32'(timeout_o), 0);
    chk("rst_m_valid", 32'(m_valid_o), 0);
    model_reset();
    @(negedge pclk);
    @(negedge pclk);
    rst = 1'b0;
  endtask

  task automatic wait_grant(input logic [NCH-1:0] req, output logic [NCH-1:0] g);
    int n = 0;
    do begin
      cycle(req, 1'b1, nb, '1);
      n++;
    end while (obs_gnt == '0 && n < 30);
    g = obs_gnt;
  endtask

  task automatic run_idle(input logic [NCH-1:0] req, input string name);
    int n = 0;
    while (obs_busy && n < 80) begin
      cycle(req, 1'b1, nb, '1);
      n++;
    end
    chk(name, 32'(obs_busy), 0);
  endtask

  // Monitor: every accepted byte is popped from the scoreboard and compared on channel and value.
  always @(negedge pclk) begin
    #2;
    if (rst) begin
      mon_beats = 0;
    end else begin
      if (done_o === 1'b1) begin
        chk("burst_len", 32'(mon_beats), BL);
        mon_beats = 0;
      end
      if (timeout_o === 1'b1) mon_beats = 0;
      if (s_valid_i === 1'b1 && s_ready_o === 1'b1) begin
        mon_ch = 3'd7;
        for (int i = 0; i < NCH; i++)
          if (m_valid_o == (NCH'(1) << i)) mon_ch = 3'(i);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected: got ch %0d byte %0h expected none", mon_ch, m_data_o);
        end else begin
          chk("beat", 32'({mon_ch, m_data_o}), 32'(exp_q.pop_front()));
        end
        mon_beats++;
      end
    end
  end

  initial begin
    logic [NCH-1:0] g;
    logic [NCH-1:0] rq, mr;
    int             n;

    do_reset();
    repeat (20) cycle('0, 1'(($urandom_range(0, 1))), 8'($urandom), '1);

    // Single burst to ch2, bytes 0x11..0x18
    nb = 8'h11;
    wait_grant(4'b0100, g);
    chk("single_gnt", 32'(g), 32'(4'b0100));
    run_idle('0, "single_idle");

    // Round-robin from reset: ch0, ch1, ch2, ch3, then ch0 again
    do_reset();
    for (int k = 0; k < 5; k++) begin
      wait_grant(4'hF, g);
      chk("rr_order", 32'(g), 32'(NCH'(1) << (k % NCH)));
      run_idle(4'hF, "rr_idle");
    end
    run_idle('0, "rr_tail");
    repeat (2) cycle('0, 1'b0, nb, '1);

    // Stalls on a ch1 burst, request dropped after beat 2
    wait_grant(4'b0010, g);
    chk("stall_gnt", 32'(g), 32'(4'b0010));
    cycle(4'b0010, 1'b1, nb, '1);
    repeat (5) cycle('0, 1'b1, nb, 4'b1101);
    repeat (3) cycle('0, 1'b0, nb, '1);
    run_idle('0, "stall_idle");

    // Reset after beat 3 of a ch3 burst, then a fresh ch3 burst
    wait_grant(4'b1000, g);
    chk("rstmid_gnt", 32'(g), 32'(4'b1000));
    repeat (2) cycle(4'b1000, 1'b1, nb, '1);
    do_reset();
    wait_grant(4'b1000, g);
    chk("rstmid_regnt", 32'(g), 32'(4'b1000));
    run_idle('0, "rstmid_idle");

`ifdef SCHED_TIMEOUT_EN
    // ch0 stalls after beat 5 until the abort
    do_reset();
    wait_grant(4'b0001, g);
    chk("to_gnt", 32'(g), 32'(4'b0001));
    repeat (4) cycle(4'b0001, 1'b1, nb, '1);
    n = 0;
    do begin
      cycle('0, 1'b0, nb, '1);
      if (!obs_to) n++;
    end while (!obs_to && n < 40);
    chk("to_delay", 32'(n), TO_CYC);
    chk("to_gnt_clear", 32'(obs_gnt), 0);
    wait_grant(4'b0011, g);
    chk("to_next_gnt", 32'(g), 32'(4'b0010));
    run_idle('0, "to_idle");
`endif

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      rq = ($urandom_range(0, 3) == 0) ? '0 : NCH'($urandom_range(0, 15));
      for (int i = 0; i < NCH; i++) mr[i] = ($urandom_range(0, 3) != 0);
      cycle(rq, 1'($urandom_range(0, 3) != 0), 8'($urandom), mr);
    end
    run_idle('0, "drain_idle");
    repeat (2) cycle('0, 1'b0, nb, '1);
    chk("exp_q_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sipo_burst_sched.md
Name: sipo_burst_sched

Overview:
- Round-robin scheduler sharing the parallel byte output of the SIPO deserializer among NUM_CH downstream consumers.
- Consumers request a burst; the scheduler grants one at a time and steers exactly BURST_LEN bytes from the SIPO valid/ready port to the granted consumer.
- Then it re-arbitrates.
- Sits entirely in the parallel clock domain, between the SIPO output and the consumer blocks.

Parameters:
- NUM_CH, 4, number of consumer channels (2..8).
- BURST_LEN, 8, bytes per granted burst (1..255).
- TIMEOUT_CYC, 64, stall cycles before burst abort (used only with SCHED_TIMEOUT_EN).

Ports:
- pclk_i  input  1  parallel clock; all logic on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- s_data_i  input  8  byte from SIPO.
- s_valid_i  input  1  SIPO byte valid.
- s_ready_o  output  1  scheduler accepts byte.
- req_i  input  NUM_CH  per-channel burst request, level.
- gnt_o  output  NUM_CH  one-hot grant, registered.
- m_data_o  output  8  byte to consumers (shared bus).
- m_valid_o  output  NUM_CH  per-channel byte valid.
- m_ready_i  input  NUM_CH  per-channel consumer ready.
- busy_o  output  1  high while in XFER.
- done_o  output  1  one-cycle pulse on last beat of a completed burst.
- timeout_o  output  1  one-cycle pulse on burst abort (tied 0 without macro).

Behaviour:
- Reset (async, asserted):
  - state=IDLE, gnt_o=0, busy_o=0, done_o=0, timeout_o=0.
  - Beat count=0; RR pointer=NUM_CH-1, so channel 0 has first priority.
  - Outputs follow the reset immediately, not on the next edge.
- States:
  - IDLE: gnt_o=0. If |req_i, winner = first set req bit searching ptr+1, ptr+2, ... modulo NUM_CH. On the next edge: gnt_o<=onehot(winner), count<=0, state<=XFER. If no request, stay in IDLE.
  - XFER: busy_o=1. Datapath is combinational, zero latency:
    - m_data_o = s_data_i.
    - m_valid_o = gnt_o & {NUM_CH{s_valid_i}}.
    - s_ready_o = |(gnt_o & m_ready_i).
  - Beat = s_valid_i & s_ready_o; count increments per beat.
  - On the beat where count==BURST_LEN-1:
    - done_o=1 in the following cycle (registered pulse).
    - ptr<=winner, gnt_o<=0, state<=IDLE.
  - Minimum one IDLE cycle between bursts; a back-to-back grant to the next requester occurs on the cycle after the return to IDLE.
- Outside XFER: s_ready_o=0, m_valid_o=0. m_data_o still mirrors s_data_i and is don't-care.
- Request rules:
  - Deasserting req_i mid-burst does not shorten the burst; the burst completes.
  - Requests arriving during XFER wait for the next arbitration.
  - A channel just served is lowest priority in the next arbitration (fairness).
  - A single requester gets consecutive bursts, each separated by one IDLE cycle.
- Stall rules:
  - s_valid_i low or m_ready_i[winner] low holds count with no state change.
  - Without the macro, XFER waits indefinitely.
- Counter width: ceil(log2(BURST_LEN+1)); no wrap occurs because the burst terminates at BURST_LEN.
- Reset asserted mid-burst discards progress. The partial burst is not signalled on done_o or timeout_o.

Optional Feature:
- Macro SCHED_TIMEOUT_EN.
- Defined:
  - A stall counter clears on every beat and on entry to XFER, and increments on each XFER cycle without a beat.
  - When it reaches TIMEOUT_CYC: state<=IDLE, gnt_o<=0, ptr<=winner, timeout_o pulses 1 cycle, done_o stays 0.
  - Bytes already delivered are not recalled.
- Undefined: no stall counter, timeout_o constant 0, TIMEOUT_CYC ignored.

Test Plan (NUM_CH=4, BURST_LEN=8):
1. Reset: hold rst_i=1 mid-clock -> gnt_o=0, busy_o=0, s_ready_o=0 immediately. Release, no requests -> stays IDLE for 20 cycles.
2. Single burst: req_i=4'b0100, SIPO streams 0x11..0x18, m_ready_i=all 1 ->
   - gnt_o=4'b0100 one cycle after request.
   - m_valid_o[2] high for 8 beats, bytes 0x11..0x18 in order.
   - done_o pulses once.
   - gnt_o=0 the cycle after the 8th beat.
3. Round-robin: req_i=4'b1111 held for 4 bursts -> grant order ch0, ch1, ch2, ch3. A fifth burst goes to ch0. Each burst is exactly 8 beats.
4. Backpressure/stall:
   - During a ch1 burst, m_ready_i[1]=0 for 5 cycles, then s_valid_i=0 for 3 cycles.
   - Required: no beats lost or duplicated, count holds, 8 beats total, then done_o.
   - req_i[1] dropped after beat 2 -> burst still completes 8 beats.
5. Reset mid-burst: assert rst_i after beat 3 of a ch3 burst -> immediate return to IDLE, no done_o. After release with req_i=4'b1000, a fresh 8-beat burst is granted to ch3.
6. (SCHED_TIMEOUT_EN, TIMEOUT_CYC=16) ch0 burst stalls after beat 5 via s_valid_i=0 ->
   - timeout_o pulses 16 stall cycles after beat 5.
   - done_o stays 0, gnt_o=0.
   - Next arbitration with req_i=4'b0011 grants ch1.
